// File: rtl/sys_sched_pkg.sv
// sys_sched_pkg: shared FSM state encoding and drain-length helper for systolic_scheduler.
package sys_sched_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  function automatic int drain_cyc(input int n);
    return 2 * n - 1;
  endfunction
endpackage

// File: rtl/skew_line.sv
// skew_line: enabled delay line of DEPTH stages with synchronous clear; DEPTH 0 is a wire.
module skew_line #(
  parameter int DEPTH = 0,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, en, clr};
    assign q = d;
  end else begin : g_reg
    logic [DEPTH-1:0][W-1:0] sr;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sr <= '0;
      else if (clr) sr <= '0;
      else if (en) begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/systolic_scheduler.sv
// systolic_scheduler: sequences one tile through an NxN systolic array with row/column input skew.
// Define SYS_SCHED_PERF_EN to build the saturating FEED-stall counter behind perf_stall.
module systolic_scheduler
  import sys_sched_pkg::*;
#(
  parameter int N = 8,
  parameter int A_W = 8,
  parameter int W_W = 8,
  parameter int K_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [K_W-1:0] k_len,
  input  logic [N-1:0]   cfg_row_mask,
  input  logic [N-1:0]   cfg_col_mask,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*A_W-1:0] in_act,
  input  logic [N*W_W-1:0] in_wgt,
  output logic           arr_en,
  output logic           arr_clr,
  output logic [N-1:0]   arr_row_en,
  output logic [N-1:0]   arr_col_en,
  output logic [N*A_W-1:0] arr_act_flat,
  output logic [N*W_W-1:0] arr_wgt_flat,
  output logic           busy,
  output logic           done,
  output logic [31:0]    perf_stall
);
  localparam int DRAIN_CYC = drain_cyc(N);
  localparam int D_W = $clog2(DRAIN_CYC + 1);
  state_t state, state_nx;
  logic [K_W-1:0] k_lat, beat_cnt;
  logic [N-1:0] row_mask, col_mask;
  logic [D_W-1:0] drain_cnt;
  logic accept;
  logic [N*A_W-1:0] act_in;
  logic [N*W_W-1:0] wgt_in;
  assign accept = (state == FEED) && in_valid;
  assign in_ready = state == FEED;
  assign arr_en = accept || (state == DRAIN);
  assign arr_clr = state == CLEAR;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign arr_row_en = busy ? row_mask : '0;
  assign arr_col_en = busy ? col_mask : '0;
  // Outside FEED the skew inputs see zeros, so DRAIN flushes the lines clean.
  assign act_in = in_ready ? in_act : '0;
  assign wgt_in = in_ready ? in_wgt : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      k_lat <= '0;
      row_mask <= '0;
      col_mask <= '0;
      beat_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        k_lat <= k_len;
        row_mask <= cfg_row_mask;
        col_mask <= cfg_col_mask;
      end
      beat_cnt <= (state == CLEAR) ? '0 : accept ? beat_cnt + 1'b1 : beat_cnt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start ? CLEAR : IDLE;
      CLEAR: state_nx = (k_lat == '0) ? DONE : FEED;
      FEED:  state_nx = (accept && beat_cnt == k_lat - 1'b1) ? DRAIN : FEED;
      DRAIN: state_nx = (drain_cnt == D_W'(DRAIN_CYC - 1)) ? DONE : DRAIN;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  for (genvar r = 0; r < N; r++) begin : g_row
    skew_line #(.DEPTH(r), .W(A_W)) u_skew (
      .clk(clk), .rst_n(rst_n), .en(arr_en), .clr(arr_clr),
      .d(act_in[r*A_W+:A_W]), .q(arr_act_flat[r*A_W+:A_W])
    );
  end
  for (genvar c = 0; c < N; c++) begin : g_col
    skew_line #(.DEPTH(c), .W(W_W)) u_skew (
      .clk(clk), .rst_n(rst_n), .en(arr_en), .clr(arr_clr),
      .d(wgt_in[c*W_W+:W_W]), .q(arr_wgt_flat[c*W_W+:W_W])
    );
  end
`ifdef SYS_SCHED_PERF_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (state == CLEAR) stall_cnt <= '0;
    else if (state == FEED && !in_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  assign perf_stall = stall_cnt;
`else
  assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_systolic_scheduler.sv
// tb_systolic_scheduler: directed self-checking bench for systolic_scheduler (N=8).
module tb_systolic_scheduler;
  localparam logic [63:0] PAT_A = 64'h0807060504030201;
  localparam logic [63:0] PAT_W = 64'h8877665544332211;
`ifdef SYS_SCHED_PERF_EN
  localparam logic [31:0] EXP_STALL = 32'd3;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [7:0] k_len = 0, cfg_row_mask = 0, cfg_col_mask = 0;
  logic in_ready, arr_en, arr_clr, busy, done;
  logic [63:0] in_act = 0, in_wgt = 0, arr_act_flat, arr_wgt_flat;
  logic [7:0] arr_row_en, arr_col_en;
  logic [31:0] perf_stall;
  logic [63:0] ea, ew;
  int n_cmp = 0, n_err = 0;
  systolic_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .cfg_row_mask(cfg_row_mask), .cfg_col_mask(cfg_col_mask),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
    .arr_en(arr_en), .arr_clr(arr_clr), .arr_row_en(arr_row_en), .arr_col_en(arr_col_en),
    .arr_act_flat(arr_act_flat), .arr_wgt_flat(arr_wgt_flat),
    .busy(busy), .done(done), .perf_stall(perf_stall)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_en"}, arr_en, 0);
    chk({tag, "_clr"}, arr_clr, 0);
    chk({tag, "_rowen"}, arr_row_en, 0);
    chk({tag, "_colen"}, arr_col_en, 0);
    chk({tag, "_act"}, arr_act_flat, 0);
    chk({tag, "_wgt"}, arr_wgt_flat, 0);
    chk({tag, "_perf"}, perf_stall, 0);
  endtask
  initial begin
    // Reset state
    tick;
    tick;
    in_act = PAT_A;
    in_wgt = PAT_W;
    #1;
    chk_idle_zero("rst");
    rst_n = 1;
    // Tile A: k_len=4, no stalls, skewed beat-0 pattern
    start = 1; k_len = 4; cfg_row_mask = 8'hFF; cfg_col_mask = 8'hFF; in_valid = 1;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      tick;
      start = 0;
      in_act = (cyc == 2) ? PAT_A : '0;
      in_wgt = (cyc == 2) ? PAT_W : '0;
      #1;
      ea = '0;
      ew = '0;
      for (int r = 0; r < 8; r++) if (cyc == 2 + r) begin
        ea[r*8+:8] = 8'(r + 1);
        ew[r*8+:8] = 8'(17 * (r + 1));
      end
      chk("a_busy", busy, 64'(cyc <= 21));
      chk("a_clr", arr_clr, 64'(cyc == 1));
      chk("a_rdy", in_ready, 64'(cyc >= 2 && cyc <= 5));
      chk("a_en", arr_en, 64'(cyc >= 2 && cyc <= 20));
      chk("a_done", done, 64'(cyc == 21));
      chk("a_act", arr_act_flat, ea);
      chk("a_wgt", arr_wgt_flat, ew);
      chk("a_rowen", arr_row_en, (cyc <= 21) ? 64'hFF : 64'h0);
    end
    // Tile B: 3-cycle stall after the first beat
    start = 1; k_len = 4;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      tick;
      start = 0;
      in_valid = !(cyc >= 3 && cyc <= 5);
      in_act = (cyc >= 2 && cyc <= 5) ? PAT_A : '0;
      in_wgt = '0;
      #1;
      ea = '0;
      if (cyc >= 2 && cyc <= 5) ea[7:0] = 8'd1;
      if (cyc >= 3 && cyc <= 6) ea[15:8] = 8'd2;
      for (int r = 2; r < 8; r++) if (cyc == r + 5) ea[r*8+:8] = 8'(r + 1);
      chk("b_en", arr_en, 64'(cyc == 2 || (cyc >= 6 && cyc <= 23)));
      chk("b_rdy", in_ready, 64'(cyc >= 2 && cyc <= 8));
      chk("b_done", done, 64'(cyc == 24));
      chk("b_act", arr_act_flat, ea);
      if (cyc == 24) chk("b_perf", perf_stall, EXP_STALL);
    end
    // Tile C: k_len=0 goes CLEAR -> DONE
    start = 1; k_len = 0; in_valid = 1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      tick;
      start = 0;
      #1;
      chk("c_clr", arr_clr, 64'(cyc == 1));
      chk("c_rdy", in_ready, 0);
      chk("c_done", done, 64'(cyc == 2));
      chk("c_busy", busy, 64'(cyc <= 2));
      if (cyc == 2) chk("c_perf", perf_stall, 0);
    end
    // Tile D: async reset during DRAIN, then k_len=1 tile
    start = 1; k_len = 4; in_act = PAT_A; in_wgt = PAT_W;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick;
      start = 0;
    end
    chk("d_pre_busy", busy, 1);
    chk("d_pre_en", arr_en, 1);
    rst_n = 0;
    #1;
    chk_idle_zero("d_rst");
    rst_n = 1;
    start = 1; k_len = 1;
    for (int cyc = 1; cyc <= 19; cyc++) begin
      tick;
      start = 0;
      #1;
      chk("d_done", done, 64'(cyc == 18));
      chk("d_busy", busy, 64'(cyc <= 18));
    end
    // Tile E: start held high, masks 0F/F0
    start = 1; k_len = 2; cfg_row_mask = 8'h0F; cfg_col_mask = 8'hF0;
    for (int cyc = 1; cyc <= 41; cyc++) begin
      tick;
      if (cyc == 30) start = 0;
      #1;
      chk("e_busy", busy, 64'(cyc != 20 && cyc < 40));
      chk("e_done", done, 64'(cyc == 19 || cyc == 39));
      chk("e_clr", arr_clr, 64'(cyc == 1 || cyc == 21));
      chk("e_rowen", arr_row_en, (cyc != 20 && cyc < 40) ? 64'h0F : 64'h0);
      chk("e_colen", arr_col_en, (cyc != 20 && cyc < 40) ? 64'hF0 : 64'h0);
    end
    // Tile F: maximum k_len
    start = 1; k_len = 8'hFF;
    for (int cyc = 1; cyc <= 273; cyc++) begin
      tick;
      start = 0;
      #1;
      chk("f_rdy", in_ready, 64'(cyc >= 2 && cyc <= 256));
      chk("f_done", done, 64'(cyc == 272));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/systolic_scheduler.md
SYSTOLIC_SCHEDULER -- requirements
Module: systolic_scheduler

Interface
REQ-001 Parameter N, default 8, array dimension (rows = columns).
REQ-002 Parameter A_W, default 8, activation width; W_W, default 8, weight width.
REQ-003 Parameter K_W, default 8, width of the reduction-length field.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request a tile; sampled only in IDLE.
REQ-007 k_len  in  K_W  reduction steps for the tile; latched with start.
REQ-008 cfg_row_mask / cfg_col_mask  in  N each  active rows/columns; latched with start.
REQ-009 in_valid  in  1, in_ready  out  1, in_act  in  N*A_W, in_wgt  in  N*W_W: one k-slice per handshake (row r in bits [r*A_W+:A_W], column c in bits [c*W_W+:W_W]).
REQ-010 arr_en  out  1, arr_clr  out  1 (drives array synchronous clear), arr_row_en / arr_col_en  out  N, arr_act_flat  out  N*A_W, arr_wgt_flat  out  N*W_W.
REQ-011 busy  out  1, done  out  1, perf_stall  out  32.

Function
REQ-012 FSM states IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-013 IDLE: start=1 latches k_len and masks, goes to CLEAR; start in any other state is ignored.
REQ-014 CLEAR lasts one cycle: arr_clr=1, arr_en=0, skew registers zeroed; next FEED, or DONE if latched k_len==0.
REQ-015 FEED: in_ready=1; beat accepted when in_valid&in_ready; arr_en=1 only on accepted cycles; on a stall (in_valid=0) arr_en=0 and skew registers hold.
REQ-016 Skew: row r activation delayed r enabled cycles, column c weight delayed c enabled cycles; row 0 and column 0 pass through combinationally.
REQ-017 After the k_len-th accepted beat, go to DRAIN; DRAIN runs exactly 2N-1 cycles with arr_en=1 and zero injected into skew inputs.
REQ-018 DONE lasts one cycle: done=1, arr_en=0; next IDLE.
REQ-019 busy=1 in every state except IDLE; in_ready=0 outside FEED.
REQ-020 arr_row_en/arr_col_en equal the latched masks while busy, all-zero in IDLE.
REQ-021 Stall-free latency: start sampled at cycle 0 gives done at cycle k_len+2N+1.
REQ-022 Beat counter is K_W bits and never wraps: k_len=2^K_W-1 is legal; the transition fires on equality.

Reset
REQ-023 rst_n=0 forces IDLE immediately, including mid-tile, and discards the tile.
REQ-024 Reset values: busy, done, in_ready, arr_en, arr_clr, masks, arr_* data, skew registers, counters and perf_stall all 0.

Configuration
REQ-025 With SYS_SCHED_PERF_EN defined, perf_stall counts FEED cycles with in_valid=0, saturates at 2^32-1, and clears on CLEAR.
REQ-026 Without SYS_SCHED_PERF_EN, perf_stall is constant 0 and no counter is built.

Structure
REQ-027 Package sys_sched_pkg holds the state enumeration and the DRAIN_CYC = 2N-1 constant function.
REQ-028 Sub-module skew_line (parameters DEPTH, W; enable and synchronous clear) implements one delay line; it is instantiated once per row and once per column (depth 0 is a wire).

Verification
REQ-029 N=8, start with k_len=4 and in_valid held 1 -> CLEAR at cycle 1, accepts on cycles 2-5, DRAIN cycles 6-20, done=1 at cycle 21 only.
REQ-030 in_act row r = r+1 on beat 0 -> arr_act_flat row r shows r+1 exactly r enabled cycles after acceptance; row 7 at the 8th arr_en cycle.
REQ-031 in_valid deasserted for 3 cycles mid-FEED -> arr_en=0 and arr_act_flat frozen for those cycles, done delayed by 3, perf_stall=3 (macro on) or 0 (macro off).
REQ-032 k_len=0 -> CLEAR then DONE; done at cycle 2; in_ready never 1.
REQ-033 rst_n pulsed low during DRAIN -> all outputs 0 asynchronously; a following start with k_len=1 completes normally, done at cycle 18.
REQ-034 start held 1 through a whole tile -> second tile starts only from IDLE after done; cfg_row_mask=8'h0F gives arr_row_en=8'h0F while busy.
